// File: rtl/present80_pkg.sv
// Shared PRESENT-80 constants, FSM state type and the pure round functions.
// All vectors use LSB numbering here: bit 63/79 is the cipher's leftmost bit.
package present80_pkg;

  localparam int ROUNDS  = 31;
  localparam int STATE_W = 64;
  localparam int KEY_W   = 80;

  // The 5-bit round counter wraps to 0 one cycle after the last round, which
  // marks the whitening/finish cycle.
  localparam logic [4:0] RC_FINISH = 5'(ROUNDS + 1);

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [STATE_W-1:0] sbox_layer64(input logic [STATE_W-1:0] x);
    logic [STATE_W-1:0] y;
    y = '0;
    for (int n = 0; n < STATE_W / 4; n++) begin
      y[4*n +: 4] = sbox4(x[4*n +: 4]);
    end
    return y;
  endfunction

  function automatic logic [STATE_W-1:0] player64(input logic [STATE_W-1:0] x);
    logic [STATE_W-1:0] y;
    y = '0;
    for (int i = 0; i < STATE_W - 1; i++) begin
      y[(16 * i) % 63] = x[i];
    end
    y[STATE_W-1] = x[STATE_W-1];
    return y;
  endfunction

  function automatic logic [KEY_W-1:0] key_update80(input logic [KEY_W-1:0] k,
                                                    input logic [4:0]       rc);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[79:19]};  // rotate left by 61
    r[79:76]   = sbox4(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

endpackage

// File: rtl/present80_round.sv
// One PRESENT-80 round, purely combinational: add round key, S-box layer,
// permutation, and the matching key-schedule step.
module present80_round
  import present80_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic [4:0]         rc_i,
  output logic [STATE_W-1:0] state_o,
  output logic [KEY_W-1:0]   key_o
);

  assign state_o = player64(sbox_layer64(state_i ^ key_i[KEY_W-1:KEY_W-STATE_W]));
  assign key_o   = key_update80(key_i, rc_i);

endmodule

// File: rtl/present80.sv
// Iterative PRESENT-80 encryptor: one round per clock, 31 rounds plus final
// key whitening, registered ciphertext with a level-type ready flag.
module present80
  import present80_pkg::*;
(
  input  logic        ck,
  input  logic        rn,
  input  logic        sta,
  input  logic [0:63] inp,
  input  logic [0:79] key,
  output logic        rdy,
  output logic [0:63] out
);

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [4:0]         rc_q, rc_d;
  logic [STATE_W-1:0] out_q, out_d;
  logic               rdy_q, rdy_d;

  logic [STATE_W-1:0] rnd_state;
  logic [KEY_W-1:0]   rnd_key;

  present80_round u_round (
    .state_i (state_q),
    .key_i   (key_q),
    .rc_i    (rc_q),
    .state_o (rnd_state),
    .key_o   (rnd_key)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;
    out_d   = out_q;
    rdy_d   = rdy_q;
    unique case (fsm_q)
      IDLE, DONE: begin
        if (sta) begin
          state_d = inp;
          key_d   = key;
          rc_d    = 5'd1;
          rdy_d   = 1'b0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        if (rc_q == RC_FINISH) begin
          out_d = state_q ^ key_q[KEY_W-1:KEY_W-STATE_W];
          rdy_d = 1'b1;
          fsm_d = DONE;
        end else begin
          state_d = rnd_state;
          key_d   = rnd_key;
          rc_d    = rc_q + 5'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins over all else.
  always_ff @(posedge ck) begin
    if (rn) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      rc_q    <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
    end
  end

  assign out = out_q;
  assign rdy = rdy_q;

endmodule

// File: tb/tb_present80.sv
// Self-checking bench for present80: known-answer vectors, handshake corner
// cases and random vectors against a loop-based PRESENT-80 reference model.
module tb_present80;

  logic        ck;
  logic        rn;
  logic        sta;
  logic [0:63] inp;
  logic [0:79] key;
  logic        rdy;
  logic [0:63] out;

  int n_tests = 0;
  int n_fail  = 0;

  present80 dut (
    .ck  (ck),
    .rn  (rn),
    .sta (sta),
    .inp (inp),
    .key (key),
    .rdy (rdy),
    .out (out)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, need summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: straight from the cipher description, arithmetic shifts and tables.
  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] k);
    int          sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    logic [63:0] s, t, p;
    logic [79:0] kr;
    int          nib, dest;
    s  = pt;
    kr = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ 64'(kr >> 16);
      t = '0;
      for (int n = 0; n < 16; n++) begin
        nib = int'((s >> (4 * n)) & 64'hF);
        t   = t | (64'(sb[nib]) << (4 * n));
      end
      p = '0;
      for (int i = 0; i < 64; i++) begin
        dest = (i == 63) ? 63 : (16 * i) % 63;
        if (t[i]) p = p | (64'd1 << dest);
      end
      s   = p;
      kr  = (kr << 61) | (kr >> 19);
      nib = int'(kr >> 76);
      kr  = (kr & ~(80'hF << 76)) | (80'(sb[nib]) << 76);
      kr  = kr ^ (80'(r) << 15);
    end
    return s ^ 64'(kr >> 16);
  endfunction

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic start_op(input logic [63:0] p, input logic [79:0] k);
    inp = p;
    key = k;
    sta = 1'b1;
    tick();
    sta = 1'b0;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (rdy !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic run_check(input string tag, input logic [63:0] p, input logic [79:0] k,
                           input logic [63:0] exp);
    int n;
    start_op(p, k);
    check({tag, "_rdy_low_at_start"}, 80'(rdy), 80'd0);
    wait_rdy(n);
    check({tag, "_latency"}, 80'(n), 80'd32);
    check({tag, "_out"}, 80'(out), 80'(exp));
  endtask

  initial begin
    int          n, seen;
    logic [63:0] p1, p2, hold_out;
    logic [79:0] k1, k2;

    rn  = 1'b1;
    sta = 1'b1;
    inp = '1;
    key = '1;
    tick();
    check("reset_rdy", 80'(rdy), 80'd0);
    check("reset_out", 80'(out), 80'd0);
    rn  = 1'b0;
    sta = 1'b0;
    seen = 0;
    repeat (40) begin
      tick();
      if (rdy === 1'b1) seen++;
    end
    check("reset_sta_ignored", 80'(seen), 80'd0);

    run_check("kat_zero", 64'h0, 80'h0, 64'h5579C1387B228445);
    hold_out = out;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_rdy", 80'(rdy), 80'd1);
      check("hold_out", 80'(out), 80'(hold_out));
    end

    run_check("kat_ones", 64'hFFFF_FFFF_FFFF_FFFF, 80'hFFFF_FFFF_FFFF_FFFF_FFFF,
              64'h3333DCD3213210D2);
    run_check("kat_pt_ones", 64'hFFFF_FFFF_FFFF_FFFF, 80'h0, 64'hA112FFC72F68417B);
    run_check("kat_key_ones", 64'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 64'hE72C46C0F5945049);

    // Second start mid-run must be ignored.
    p1 = {$urandom, $urandom};
    k1 = {$urandom, $urandom, 16'($urandom)};
    p2 = ~p1;
    k2 = ~k1;
    start_op(p1, k1);
    repeat (9) tick();
    start_op(p2, k2);
    wait_rdy(n);
    check("midrun_sta_latency", 80'(n + 10), 80'd32);
    check("midrun_sta_out", 80'(out), 80'(ref_enc(p1, k1)));

    // Reset during a run aborts it.
    start_op(p2, k2);
    repeat (14) tick();
    rn = 1'b1;
    tick();
    rn = 1'b0;
    check("midrun_reset_rdy", 80'(rdy), 80'd0);
    check("midrun_reset_out", 80'(out), 80'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (rdy === 1'b1) seen++;
    end
    check("midrun_reset_no_completion", 80'(seen), 80'd0);
    run_check("after_reset", p2, k2, ref_enc(p2, k2));

    // Held start: one run, then immediate restart once DONE is reached.
    p1 = {$urandom, $urandom};
    k1 = {$urandom, $urandom, 16'($urandom)};
    inp = p1;
    key = k1;
    sta = 1'b1;
    tick();
    wait_rdy(n);
    check("held_sta_latency", 80'(n), 80'd32);
    check("held_sta_out", 80'(out), 80'(ref_enc(p1, k1)));
    tick();
    sta = 1'b0;
    check("held_sta_restart_rdy", 80'(rdy), 80'd0);
    wait_rdy(n);
    check("held_sta_restart_latency", 80'(n), 80'd32);
    check("held_sta_restart_out", 80'(out), 80'(ref_enc(p1, k1)));

    for (int i = 0; i < 8; i++) begin
      p1 = {$urandom, $urandom};
      k1 = {$urandom, $urandom, 16'($urandom)};
      run_check($sformatf("rand%0d", i), p1, k1, ref_enc(p1, k1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
